// File: rtl/prog_loader.sv
// prog_loader: boot-time loader that writes a framed byte stream into the
// processor memory from address 0 and holds the core in reset until the
// frame is complete. Frame: length byte N, N payload bytes, then a checksum
// byte when LOADER_CHECKSUM_EN is defined. All outputs are registered.
module prog_loader #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   bytes_loaded
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
`ifdef LOADER_CHECKSUM_EN
        S_SUM  = 3'd2,
`endif
        S_RUN  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    bytes_q, bytes_d;
    logic                in_ready_q, in_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_wdata_q, mem_wdata_d;
    logic                core_reset_q, core_reset_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          sum_q, sum_d;
`endif

    logic accept;
    logic last_payload;
    logic do_write;
    logic to_run;
    logic to_err;

    assign accept       = in_valid & in_ready_q;
    assign last_payload = (cnt_q + CNT_W'(1)) == len_q;

    // Next-state and next-output logic for the frame parser.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        bytes_d      = bytes_q + CNT_W'(mem_we_q);
        in_ready_d   = in_ready_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        core_reset_d = core_reset_q;
        done_d       = done_q;
        error_d      = error_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        do_write     = 1'b0;
        to_run       = 1'b0;
        to_err       = 1'b0;

        case (state_q)
            S_LEN: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    if (in_data == 8'd0 || 32'(in_data) > DEPTH || in_last) begin
                        to_err = 1'b1;
                    end else begin
                        len_d   = CNT_W'(in_data);
                        cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                        sum_d   = 8'd0;
`endif
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    if (!last_payload) begin
                        // An early end-of-frame is rejected before it is written.
                        if (in_last) to_err = 1'b1;
                        else         do_write = 1'b1;
                    end else begin
`ifdef LOADER_CHECKSUM_EN
                        if (in_last) begin
                            to_err = 1'b1;
                        end else begin
                            do_write = 1'b1;
                            state_d  = S_SUM;
                        end
`else
                        if (in_last) begin
                            do_write = 1'b1;
                            to_run   = 1'b1;
                        end else begin
                            to_err = 1'b1;
                        end
`endif
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_SUM: begin
                if (accept) begin
                    if (in_last && (sum_q + in_data) == 8'd0) to_run = 1'b1;
                    else                                      to_err = 1'b1;
                end
            end
`endif
            S_RUN: begin
                // Entered one edge after the final accept, so the last write
                // has landed before the core is released.
                in_ready_d   = 1'b0;
                done_d       = 1'b1;
                core_reset_d = 1'b0;
            end
            S_ERR: begin
                in_ready_d   = 1'b0;
                error_d      = 1'b1;
                core_reset_d = 1'b1;
            end
            default: begin
                to_err = 1'b1;
            end
        endcase

        if (do_write) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = ADDR_W'(cnt_q);
            mem_wdata_d = in_data;
            cnt_d       = cnt_q + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
            sum_d       = sum_q + in_data;
`endif
        end
        if (to_run) begin
            state_d    = S_RUN;
            in_ready_d = 1'b0;
        end
        if (to_err) begin
            state_d    = S_ERR;
            in_ready_d = 1'b0;
            error_d    = 1'b1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_LEN;
            len_q        <= '0;
            cnt_q        <= '0;
            bytes_q      <= '0;
            in_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 8'd0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            bytes_q      <= bytes_d;
            in_ready_q   <= in_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign in_ready     = in_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign core_reset   = core_reset_q;
    assign done         = done_q;
    assign error        = error_q;
    assign bytes_loaded = bytes_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized frames checked against a frame-level model.
// Honours LOADER_CHECKSUM_EN the same way as the design.
module tb_prog_loader;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_last;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              core_reset;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   bytes_loaded;

    prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_reset(core_reset),
        .done(done), .error(error), .bytes_loaded(bytes_loaded)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Frame under test and what the model expects from it.
    logic [7:0] fr_data [0:63];
    logic       fr_last [0:63];
    int         fr_len;
    logic [7:0] pay [0:63];
    int         exp_acc;
    bit         exp_run;
    bit         exp_term;
    int         wq_addr [$];
    logic [7:0] wq_data [$];
    logic [7:0] tb_mem [0:(1<<ADDR_W)-1];

    // Monitor bookkeeping.
    bit mon_en = 1'b0;
    bit rst_seen = 1'b0;
    int rel = 0;
    int acc_cnt = 0;
    int since = -1;
    int pulses = 0;
    bit acc_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: which bytes get accepted, which are written, and the outcome.
    task automatic compute_expect();
        int n;
        logic [7:0] sum;
        wq_addr.delete();
        wq_data.delete();
        exp_acc  = 1;
        exp_run  = 1'b0;
        exp_term = 1'b1;
        n = int'(fr_data[0]);
        if (n == 0 || n > int'(DEPTH) || fr_last[0]) return;
        sum = 8'h00;
        for (int k = 1; k < fr_len; k++) begin
            exp_acc = k + 1;
            if (k < n) begin
                if (fr_last[k]) return;
                wq_addr.push_back(k - 1);
                wq_data.push_back(fr_data[k]);
                sum = sum + fr_data[k];
            end else if (k == n) begin
`ifdef LOADER_CHECKSUM_EN
                if (fr_last[k]) return;
                wq_addr.push_back(k - 1);
                wq_data.push_back(fr_data[k]);
                sum = sum + fr_data[k];
`else
                if (!fr_last[k]) return;
                wq_addr.push_back(k - 1);
                wq_data.push_back(fr_data[k]);
                exp_run = 1'b1;
                return;
`endif
            end else begin
                exp_run = fr_last[k] && (8'(sum + fr_data[k]) == 8'h00);
                return;
            end
        end
        exp_term = 1'b0;
    endtask

    // Build a frame of length n from pay[]; last_pos < 0 marks the final byte.
    task automatic make_frame(input int n, input int last_pos, input bit bad_sum);
        logic [7:0] s;
        s = 8'h00;
        fr_data[0] = 8'(n);
        fr_len = 1 + n;
        for (int i = 0; i < n; i++) begin
            fr_data[1 + i] = pay[i];
            s = s + pay[i];
        end
`ifdef LOADER_CHECKSUM_EN
        fr_data[fr_len] = 8'(8'h00 - s + 8'(bad_sum));
        fr_len++;
`else
        if (bad_sum) s = 8'h00;
`endif
        for (int i = 0; i < 64; i++) fr_last[i] = 1'b0;
        fr_last[(last_pos < 0) ? fr_len - 1 : last_pos] = 1'b1;
    endtask

    // Offer the bytes the model says will be accepted; called just after a negedge.
    task automatic drive(input int mode);
        int i;
        int wait_c;
        int tog;
        bit v;
        bit acc;
        i = 0; wait_c = 0; tog = 0;
        while (i < exp_acc) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = tog[0];
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            tog++;
            in_valid = v;
            in_data  = fr_data[i];
            in_last  = fr_last[i];
            acc = v && in_ready;
            @(negedge clk);
            if (acc) begin
                i++;
                wait_c = 0;
            end else begin
                wait_c++;
                if (wait_c > 64) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: byte %0d of %0d never accepted", i, exp_acc);
                    break;
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (2) @(negedge clk);
        chk("writes_drained", 32'(wq_addr.size()), 32'd0);
        wq_addr.delete();
        wq_data.delete();
        reset = 1'b1;
    endtask

    task automatic run_frame(input int mode);
        compute_expect();
        drive(mode);
        repeat (4) @(negedge clk);
        chk("writes_drained", 32'(wq_addr.size()), 32'd0);
        if (exp_term) begin
            chk("final_done", 32'(done), 32'(exp_run));
            chk("final_error", 32'(error), 32'(!exp_run));
            // Bytes offered after the frame must be ignored.
            in_valid = 1'b1;
            in_data  = 8'hEE;
            in_last  = 1'($urandom_range(0, 1));
            repeat (3) @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            @(negedge clk);
        end
    endtask

    // Edge bookkeeping: accepts, completed write pulses, cycles since the frame ended.
    always @(posedge clk) begin
        if (!reset) begin
            rel = 0; acc_cnt = 0; since = -1; pulses = 0; acc_last = 1'b0;
        end else begin
            if (rel < 1000) rel++;
            if (mem_we) pulses++;
            if (since >= 0 && since < 1000) since++;
            acc_last = in_valid && in_ready;
            if (acc_last) begin
                acc_cnt++;
                if (exp_term && acc_cnt == exp_acc) since = 0;
            end
        end
        rst_seen = reset;
    end

    // Compare process: every cycle, outputs against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_seen) begin
                chk("rst_in_ready", 32'(in_ready), 32'd0);
                chk("rst_mem_we", 32'(mem_we), 32'd0);
                chk("rst_mem_addr", 32'(mem_addr), 32'd0);
                chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
                chk("rst_core_reset", 32'(core_reset), 32'd1);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_error", 32'(error), 32'd0);
                chk("rst_bytes_loaded", 32'(bytes_loaded), 32'd0);
            end else begin
                chk("in_ready", 32'(in_ready), 32'(rel >= 1 && since < 0));
                chk("done", 32'(done), 32'(exp_run && since >= 1));
                chk("error", 32'(error), 32'(exp_term && !exp_run && since >= 0));
                chk("core_reset", 32'(core_reset), 32'(!(exp_run && since >= 1)));
                chk("bytes_loaded", 32'(bytes_loaded), 32'(pulses));
                if (mem_we) begin
                    tb_mem[mem_addr] = mem_wdata;
                    chk("we_after_accept", 32'(acc_last), 32'd1);
                    if (wq_addr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h", mem_addr, mem_wdata);
                    end else begin
                        chk("mem_addr", 32'(mem_addr), 32'(wq_addr.pop_front()));
                        chk("mem_wdata", 32'(mem_wdata), 32'(wq_data.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        exp_acc  = 0;
        exp_run  = 1'b0;
        exp_term = 1'b0;
        fr_len   = 0;
        for (int i = 0; i < 64; i++) begin
            pay[i] = 8'h00; fr_data[i] = 8'h00; fr_last[i] = 1'b0;
        end
        for (int i = 0; i < (1 << ADDR_W); i++) tb_mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        // N=3, payload 11 22 33, valid held high.
        do_reset();
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        make_frame(3, -1, 1'b0);
        run_frame(0);
        chk("lit_mem0", 32'(tb_mem[0]), 32'h11);
        chk("lit_mem1", 32'(tb_mem[1]), 32'h22);
        chk("lit_mem2", 32'(tb_mem[2]), 32'h33);
        chk("lit_bytes3", 32'(bytes_loaded), 32'd3);
        chk("lit_done", 32'(done), 32'd1);
        chk("lit_core_run", 32'(core_reset), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        chk("lit_checksum_byte", 32'(fr_data[4]), 32'h9A);

        // Same payload with checksum 0x9B.
        do_reset();
        make_frame(3, -1, 1'b1);
        run_frame(0);
        chk("lit_sum_error", 32'(error), 32'd1);
        chk("lit_sum_core_held", 32'(core_reset), 32'd1);
        chk("lit_sum_bytes3", 32'(bytes_loaded), 32'd3);
        chk("lit_sum_ready", 32'(in_ready), 32'd0);
`endif

        // Length 0 and length 0x11 > DEPTH.
        do_reset();
        make_frame(0, -1, 1'b0);
        run_frame(0);
        chk("lit_len0_error", 32'(error), 32'd1);
        chk("lit_len0_bytes", 32'(bytes_loaded), 32'd0);
        do_reset();
        make_frame(17, -1, 1'b0);
        run_frame(0);
        chk("lit_len17_error", 32'(error), 32'd1);
        chk("lit_len17_bytes", 32'(bytes_loaded), 32'd0);

        // N=14 with valid toggling, address 13 = 0x2A.
        do_reset();
        for (int i = 0; i < 14; i++) pay[i] = 8'($urandom);
        pay[13] = 8'h2A;
        make_frame(14, -1, 1'b0);
        run_frame(1);
        chk("lit_mem13", 32'(tb_mem[13]), 32'h2A);
        chk("lit_n14_done", 32'(done), 32'd1);
        chk("lit_n14_bytes", 32'(bytes_loaded), 32'd14);

        // N=4 with in_last on the 2nd payload byte.
        do_reset();
        make_frame(4, 2, 1'b0);
        run_frame(0);
        chk("lit_early_last_bytes", 32'(bytes_loaded), 32'd1);
        chk("lit_early_last_error", 32'(error), 32'd1);

        // Reset after 2 of 5 payload bytes, then a full N=1 frame.
        do_reset();
        for (int i = 0; i < 5; i++) pay[i] = 8'(8'h40 + i);
        make_frame(5, -1, 1'b0);
        fr_len = 3;
        run_frame(0);
        chk("lit_partial_bytes", 32'(bytes_loaded), 32'd2);
        do_reset();
        pay[0] = 8'h5C;
        make_frame(1, -1, 1'b0);
        run_frame(2);
        chk("lit_n1_mem0", 32'(tb_mem[0]), 32'h5C);
        chk("lit_n1_done", 32'(done), 32'd1);

        // Random frames, including bad lengths, misplaced in_last and bad sums.
        for (int r = 0; r < 40; r++) begin
            int n;
            int lp;
            bit bs;
            do_reset();
            for (int i = 0; i < 40; i++) pay[i] = 8'($urandom);
            n  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 20))
                                             : int'($urandom_range(1, DEPTH));
            lp = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n)) : -1;
            bs = ($urandom_range(0, 4) == 0);
            make_frame(n, lp, bs);
            run_frame(int'($urandom_range(0, 2)));
        end

        do_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader for the simple processor. It accepts a framed byte stream over a valid/ready handshake and writes each payload byte into the processor's 8-bit data/instruction memory at sequential addresses from 0. It holds the core in reset until the frame is complete, then releases it. It is the writer counterpart to the memory read-out path that `top` exposes.

## Interface
Parameters:
- `ADDR_W`, default 4: memory address width. The loadable region has `2**ADDR_W` bytes.
- `DEPTH`, default 16: maximum payload length. Must be ≤ `2**ADDR_W`.

Ports:
- `clk` input, 1 bit: single clock. All logic is on the rising edge.
- `reset` input, 1 bit: reset is synchronous and active-low (0 = reset), sampled on the `clk` rising edge.
- `in_valid` input, 1 bit: the source has a byte on `in_data`.
- `in_data` input, 8 bits: stream byte.
- `in_last` input, 1 bit: marks the final byte of the frame.
- `in_ready` output, 1 bit: the loader accepts a byte this cycle. Registered.
- `mem_we` output, 1 bit: memory write strobe, one cycle per byte.
- `mem_addr` output, `ADDR_W` bits: write address.
- `mem_wdata` output, 8 bits: write data.
- `core_reset` output, 1 bit: active-high reset to the processor.
- `done` output, 1 bit: load finished; the core is running.
- `error` output, 1 bit: frame rejected; the core stays held.
- `bytes_loaded` output, `ADDR_W+1` bits: count of payload bytes written.

## Operation
- A byte is accepted when `in_valid & in_ready` is true on a rising edge.
- Frame format:
  - Length byte N.
  - N payload bytes.
  - A checksum byte, only when `LOADER_CHECKSUM_EN` is defined.
  - `in_last` must be high on the final byte of the frame and only there.
- State machine, entered at reset in `S_LEN`:
  - `S_LEN`: accept N.
    - N = 0, N > `DEPTH`, or `in_last` high → `S_ERR`.
    - Otherwise latch N, clear the counter and the sum, go to `S_DATA`.
  - `S_DATA`: for each accepted byte, write it to address = counter, then increment the counter. Also add the byte to an 8-bit sum (mod 256).
    - If this is byte N and the checksum is disabled: `in_last` must be 1 → `S_RUN`, otherwise → `S_ERR`.
    - If this is byte N and the checksum is enabled: `in_last` must be 0 → `S_SUM`.
    - `in_last` high before byte N → `S_ERR`, and that byte is not written.
  - `S_SUM`: accept the checksum byte.
    - Requires `in_last` = 1 and (sum + byte) mod 256 = 0 → `S_RUN`.
    - Otherwise → `S_ERR`.
  - `S_RUN`: terminal. `in_ready` = 0, `done` = 1, `core_reset` = 0.
  - `S_ERR`: terminal. `in_ready` = 0, `error` = 1, `core_reset` = 1.
- Only reset leaves `S_RUN` or `S_ERR`.
- Bytes offered while `in_ready` = 0 are ignored. The source must hold them; no data is dropped.
- `bytes_loaded` equals the number of completed `mem_we` pulses.

## Timing
- Reset values, held while `reset` = 0:
  - `in_ready` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `core_reset` = 1, `done` = 0, `error` = 0, `bytes_loaded` = 0.
- `in_ready` rises on the first edge after `reset` returns to 1.
- Write latency: a byte accepted at edge t produces `mem_we` = 1 with its address and data during the cycle after t (a registered write).
- `mem_we` is never high for two cycles without two accepted bytes.
- Release timing, for a final accept at edge t:
  - `in_ready` falls after edge t.
  - The last `mem_we` pulse, if any, is in cycle t+1.
  - `core_reset` falls and `done` rises after edge t+1, so the core never runs before the last write lands.
- Error timing: `error` rises after the offending accept edge. No further `mem_we` pulses occur.
- Reset asserted mid-frame: everything returns to reset values on that edge. The partial memory contents are left as written.
- Back-to-back accepts (`in_valid` held high) sustain one byte per cycle.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - `S_SUM` exists.
  - The frame is N+2 bytes.
  - A checksum mismatch → `S_ERR`.
- `LOADER_CHECKSUM_EN` undefined:
  - No sum register and no `S_SUM`.
  - The frame is N+1 bytes.
  - `in_last` on payload byte N completes the load.

## Test plan
- Load N=3 with payload 0x11, 0x22, 0x33, `in_valid` held high:
  - Three `mem_we` pulses at addresses 0, 1, 2 with those data values.
  - `bytes_loaded` = 3.
  - `done` = 1 and `core_reset` = 0 two edges after the last accept.
  - With `LOADER_CHECKSUM_EN`, a trailing checksum byte 0x9A is required.
- With `LOADER_CHECKSUM_EN`, send the same payload with checksum 0x9B:
  - `error` = 1, `core_reset` stays 1.
  - `bytes_loaded` = 3, `in_ready` = 0.
- Send length byte 0x00, then separately 0x11 with `DEPTH` = 16:
  - `error` = 1 right after the length byte.
  - No `mem_we` pulse.
- Load N=14 with `in_valid` toggling every other cycle and address 13 = 0x2A:
  - The byte at address 13 is written with 0x2A.
  - `done` asserts; no byte is lost or duplicated.
- Send N=4 with `in_last` on the 2nd payload byte:
  - Only 1 write occurs.
  - `error` = 1.
- Assert `reset` = 0 after 2 of 5 payload bytes:
  - All outputs return to reset values.
  - A subsequent full N=1 frame loads at address 0 and completes.
